// File: rtl/alu_issue_if.sv
// alu_issue_if: bundles the request, ALU-side and response signals of the ALU issue stage.
//   in_*   : request handshake (valid/ready) carrying opcode, operands and destination tag
//   alu_*  : registered opcode/operands out to the ALU, result back from the ALU
//   out_*  : response handshake (valid/ready) carrying result, tag and illegal flag
// Modports: master drives requests, the ALU result and out_ready; slave is the issue stage.
interface alu_issue_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_opcode;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_rd;

  logic [3:0]       alu_opcode;
  logic [XLEN-1:0]  alu_a;
  logic [XLEN-1:0]  alu_b;
  logic [XLEN-1:0]  alu_result;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_rd;
  logic             out_illegal;

  modport master (
    output in_valid, in_opcode, in_a, in_b, in_rd, alu_result, out_ready,
    input  in_ready, alu_opcode, alu_a, alu_b, out_valid, out_result, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, in_rd, alu_result, out_ready,
    output in_ready, alu_opcode, alu_a, alu_b, out_valid, out_result, out_rd, out_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: issue stage in front of the ALU. Accepts one op per handshake, holds registered
// opcode/operands on the ALU for the op's result latency, captures the result with its tag and
// offers it to writeback.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-high
//   bus  : alu_issue_if.slave (request in_*, ALU alu_*, response out_*)
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no op in flight, ready for a request
// EXEC   | operands applied to ALU; combinational ops captured here
// SETTLE | waiting REG_LAT cycles for registered ALU ops (ADD/SUB/MUL)
// RESP   | response valid, held until out_ready; can accept next op same edge
module alu_issue #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int REG_LAT = 1
) (
  input logic       clk,
  input logic       rst,
  alu_issue_if.slave bus
);

  localparam int CNT_W = (REG_LAT < 2) ? 1 : $clog2(REG_LAT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, SETTLE, RESP} state_e;
  typedef enum logic [1:0] {CLS_REG, CLS_COMB, CLS_ILL} op_class_e;

  function automatic op_class_e op_class(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010:                            op_class = CLS_REG;
      4'b0100, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010: op_class = CLS_COMB;
      default:                                              op_class = CLS_ILL;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [TAG_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic             ill_q, ill_d;
  logic             in_ready;
  logic             accept;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rd_d     = rd_q;
    res_d    = res_q;
    ill_d    = ill_q;

    // Ready never looks at in_valid, so upstream can't form a combinational loop through us.
    in_ready = (state_q == IDLE) | ((state_q == RESP) & bus.out_ready);
    accept   = in_ready & bus.in_valid;

    case (state_q)
      EXEC: begin
        if (op_class(op_q) == CLS_COMB) begin
          res_d   = bus.alu_result;
          ill_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d   = CNT_W'(REG_LAT);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          res_d   = bus.alu_result;
          ill_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    // Accept overrides the RESP drain so a same-edge drain+accept goes straight to the new op.
    if (accept) begin
      op_d = bus.in_opcode;
      a_d  = bus.in_a;
      b_d  = bus.in_b;
      rd_d = bus.in_rd;
      if (op_class(bus.in_opcode) == CLS_ILL) begin
        res_d   = '0;
        ill_d   = 1'b1;
        state_d = RESP;
      end else begin
        ill_d   = 1'b0;
        state_d = EXEC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.alu_opcode  = op_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.out_valid   = (state_q == RESP);
  assign bus.out_result  = res_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_illegal = ill_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed bench for alu_issue with a behavioural ALU (ADD/SUB/MUL registered,
// logic/shift combinational).
module tb_alu_issue;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  alu_issue_if #(.XLEN(32), .TAG_W(5)) bus ();

  alu_issue #(.XLEN(32), .TAG_W(5), .REG_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU
  logic [31:0] reg_res;
  always @(posedge clk) begin
    case (bus.alu_opcode)
      OP_ADD:  reg_res <= bus.alu_a + bus.alu_b;
      OP_SUB:  reg_res <= bus.alu_a - bus.alu_b;
      OP_MUL:  reg_res <= bus.alu_a * bus.alu_b;
      default: reg_res <= 32'hDEAD_BEEF;
    endcase
  end

  logic [4:0] shamt;
  assign shamt = bus.alu_b[4:0];

  always_comb begin
    bus.alu_result = 32'hDEAD_BEEF;
    case (bus.alu_opcode)
      OP_ADD, OP_SUB, OP_MUL: bus.alu_result = reg_res;
      OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
      OP_OR:   bus.alu_result = bus.alu_a | bus.alu_b;
      OP_XOR:  bus.alu_result = bus.alu_a ^ bus.alu_b;
      4'b1000: bus.alu_result = bus.alu_a << shamt;
      4'b1001: bus.alu_result = bus.alu_a >> shamt;
      OP_SRA:  bus.alu_result = $unsigned($signed(bus.alu_a) >>> shamt);
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_rd     = rd;
    bus.in_valid  = 1'b1;
    check("accept_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; counts cycles to out_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                        input logic exp_ill, input int exp_lat);
    int lat;
    bus.out_ready = 1'b1;
    issue(op, a, b, rd);
    wait_valid(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, 64'(bus.out_result), 64'(exp_res));
    check({tag, "_rd"},  64'(bus.out_rd), 64'(rd));
    check({tag, "_ill"}, 64'(bus.out_illegal), 64'(exp_ill));
    @(posedge clk);
    #1;
    check({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_rd     = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_result", 64'(bus.out_result), 64'd0);
    check("rst_out_rd", 64'(bus.out_rd), 64'd0);
    check("rst_out_illegal", 64'(bus.out_illegal), 64'd0);
    check("rst_alu_a", 64'(bus.alu_a), 64'd0);
    check("rst_alu_opcode", 64'(bus.alu_opcode), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;

    run_op("add", OP_ADD, 32'd5, 32'd7, 5'd3, 32'd12, 1'b0, 3);
    run_op("and", OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 5'd1, 32'h0000_00F0, 1'b0, 2);
    run_op("sra", OP_SRA, 32'h8000_0000, 32'd4, 5'd2, 32'hF800_0000, 1'b0, 2);
    run_op("sub", OP_SUB, 32'd3, 32'd5, 5'd4, 32'hFFFF_FFFE, 1'b0, 3);
    run_op("mul", OP_MUL, 32'h0001_0000, 32'h0001_0000, 5'd5, 32'h0000_0000, 1'b0, 3);
    run_op("illegal", 4'b0011, 32'd77, 32'd88, 5'd9, 32'd0, 1'b1, 1);
    run_op("illegal_f", 4'b1111, 32'd1, 32'd2, 5'd31, 32'd0, 1'b1, 1);

    // Backpressure in RESP
    bus.out_ready = 1'b0;
    issue(OP_OR, 32'h0F, 32'hF0, 5'd7);
    wait_valid(lat);
    check("bp_lat", 64'(lat), 64'd2);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_out_result", 64'(bus.out_result), 64'hFF);
      check("bp_out_rd", 64'(bus.out_rd), 64'd7);
      check("bp_alu_a", 64'(bus.alu_a), 64'h0F);
      check("bp_alu_b", 64'(bus.alu_b), 64'hF0);
      check("bp_alu_op", 64'(bus.alu_opcode), 64'(OP_OR));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_consumed", 64'(bus.out_valid), 64'd0);
    check("bp_idle_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    check("bp_once", 64'(bus.out_valid), 64'd0);

    // Back-to-back: same-edge drain of XOR and accept of SUB
    issue(OP_XOR, 32'hFF, 32'h0F, 5'd4);
    wait_valid(lat);
    check("b2b_xor_lat", 64'(lat), 64'd2);
    check("b2b_xor_res", 64'(bus.out_result), 64'hF0);
    bus.in_opcode = OP_SUB;
    bus.in_a      = 32'd10;
    bus.in_b      = 32'd1;
    bus.in_rd     = 5'd6;
    bus.in_valid  = 1'b1;
    #1;
    check("b2b_resp_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("b2b_valid_drop", 64'(bus.out_valid), 64'd0);
    check("b2b_alu_a", 64'(bus.alu_a), 64'd10);
    wait_valid(lat);
    check("b2b_sub_lat", 64'(lat), 64'd3);
    check("b2b_sub_res", 64'(bus.out_result), 64'd9);
    check("b2b_sub_rd", 64'(bus.out_rd), 64'd6);
    @(posedge clk);
    #1;

    // Back-to-back into an illegal op keeps out_valid high
    issue(OP_AND, 32'h3, 32'h6, 5'd8);
    wait_valid(lat);
    check("b2i_and_res", 64'(bus.out_result), 64'h2);
    bus.in_opcode = 4'b0101;
    bus.in_rd     = 5'd11;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("b2i_valid_held", 64'(bus.out_valid), 64'd1);
    check("b2i_ill", 64'(bus.out_illegal), 64'd1);
    check("b2i_rd", 64'(bus.out_rd), 64'd11);
    check("b2i_res", 64'(bus.out_result), 64'd0);
    @(posedge clk);
    #1;

    // Reset during SETTLE abandons the op
    issue(OP_ADD, 32'd100, 32'd200, 5'd12);
    @(posedge clk);
    #1;
    check("rst_mid_pre_valid", 64'(bus.out_valid), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_mid_alu_a", 64'(bus.alu_a), 64'd0);
    check("rst_mid_alu_b", 64'(bus.alu_b), 64'd0);
    check("rst_mid_alu_op", 64'(bus.alu_opcode), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_no_resp", 64'(bus.out_valid), 64'd0);

    run_op("post_rst", OP_ADD, 32'd1, 32'd1, 5'd13, 32'd2, 1'b0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
